seq_det_ctrl: RTL

Programmable serial-pattern detection controller. Holds a configurable PAT_W-bit pattern, match mode and match target. It arms, runs and stops detection on a qualified serial bit stream. Produces a Mealy-style same-cycle match pulse, a saturating match count and a sticky done flag. Sits between the config/control logic and the serial input stream, replacing fixed hard-coded detectors.

---
 rtl/seq_det_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detector with arm/run/stop control.
// Produces a same-cycle match pulse, a saturating match count and a sticky done flag.
module seq_det_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [HIST_W-1:0]  hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [PAT_W-1:0]   window;
    logic               hit_target;
    logic               cfg_ok;
    logic               arm;

    assign window = {hist_q, in};
    assign cfg_ok = (state == S_IDLE) || (state == S_DONE);
    assign arm    = cfg_ok && (state_nxt == S_ARMED);

    // Widened compare so a saturated count can never alias onto the target.
    assign hit_target = (tgt_q != '0) &&
                        ((CNT_W+1)'(match_cnt) + (CNT_W+1)'(1) == (CNT_W+1)'(tgt_q));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over a same-cycle completion
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (match && hit_target) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (start) begin
                    state_nxt = S_ARMED;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Mealy match pulse
    always_comb begin
        match = 1'b0;
        if ((state == S_ARMED) && in_valid && !abort &&
            (fill_q == FILL_MAX) && (window == pat_q)) begin
            match = 1'b1;
        end
    end

    // Config, history, counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (cfg_ok && cfg_we) begin
                pat_q <= cfg_pattern;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end

            if (arm) begin
                hist_q    <= '0;
                fill_q    <= '0;
                match_cnt <= '0;
                done      <= 1'b0;
            end else if (state == S_ARMED) begin
                if (abort) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else if (in_valid) begin
                    if (match && !ovl_q) begin
                        hist_q <= '0;
                        fill_q <= '0;
                    end else begin
                        hist_q <= window[HIST_W-1:0];
                        if (fill_q != FILL_MAX) begin
                            fill_q <= fill_q + FILL_W'(1);
                        end
                    end
                    if (match && (match_cnt != CNT_MAX)) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                    end
                    if (match && hit_target) begin
                        done <= 1'b1;
                    end
                end
            end else if ((state == S_DONE) && abort) begin
                done <= 1'b0;
            end

            busy <= (state_nxt == S_ARMED);
        end
    end

endmodule
